fetch_stage: RTL and testbench

- Instruction-fetch stage and IF/ID pipeline register.
- Sits directly upstream of the decode stage and hazard-detection logic. Its registered instruction fields drive the decode-side opcode/r1/r2/w inputs. It consumes the hazard unit's stall output and the branch-resolution redirect.
- Owns the PC, the instruction-memory address, bubble/flush insertion, HALT handling and a stall-cycle performance counter.

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/if_id_reg.sv | 44 ++++
 rtl/fetch_stage.sv | 100 ++++++++++
 tb/tb_fetch_stage.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, instruction field layout and the fetch FSM state type.
package cpu_pkg;

  localparam int INSTR_W = 16;
  localparam int REG_W   = 3;
  localparam int OPC_W   = 4;

  localparam int OPC_LSB = 12;
  localparam int W_LSB   = 9;
  localparam int R1_LSB  = 6;
  localparam int R2_LSB  = 3;

  localparam logic [OPC_W-1:0]   OP_NOP    = 4'd0;
  localparam logic [OPC_W-1:0]   OP_HALT   = 4'd15;
  localparam logic [INSTR_W-1:0] NOP_INSTR = {OP_NOP, {(INSTR_W-OPC_W){1'b0}}};

  typedef enum logic {
    FETCH_RUN,
    FETCH_HALTED
  } fetch_state_e;

  function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[OPC_LSB +: OPC_W];
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats hold, hold beats load.
module if_id_reg
  import cpu_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_flush,
  input  logic               i_hold,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [PC_W-1:0]    i_pc,
  input  logic               i_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [PC_W-1:0]    o_pc,
  output logic               o_valid
);

  logic [INSTR_W-1:0] r_instr;
  logic [PC_W-1:0]    r_pc;
  logic               r_valid;

  // NOTE: registers are written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr <= NOP_INSTR;
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else if (i_flush) begin
      // A flushed slot keeps its old pc; only the instruction and valid bit matter.
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (!i_hold) begin
      r_instr <= i_instr;
      r_pc    <= i_pc;
      r_valid <= i_valid;
    end
  end

  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, the RUN/HALTED fetch FSM, the stall counter and the IF/ID register.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] id_instr,
  output logic [OPC_W-1:0]   id_opcode,
  output logic [REG_W-1:0]   id_w,
  output logic [REG_W-1:0]   id_r1,
  output logic [REG_W-1:0]   id_r2,
  output logic [PC_W-1:0]    id_pc,
  output logic               id_valid,
  output logic               halted,
  output logic [CNT_W-1:0]   stall_cycles
);

  fetch_state_e       r_state;
  fetch_state_e       w_state_next;
  logic [PC_W-1:0]    r_pc;
  logic [PC_W-1:0]    w_pc_next;
  logic [CNT_W-1:0]   r_stall_cnt;
  logic               w_running;
  logic               w_fetch_halt;
  logic [INSTR_W-1:0] w_load_instr;

  assign w_running    = (r_state == FETCH_RUN);
  assign w_fetch_halt = (opcode_of(imem_data) == OP_HALT);

  // NOTE: defaults first, so every path assigns every output and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    if (branch_taken) begin
      w_pc_next    = branch_target;
      w_state_next = FETCH_RUN;
    end else if (!stall && w_running) begin
      // A fetched HALT parks the PC on itself.
      if (w_fetch_halt) begin
        w_state_next = FETCH_HALTED;
      end else begin
        w_pc_next = r_pc + PC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FETCH_RUN;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (stall && !branch_taken && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  // Once halted, each unstalled edge shifts a bubble in behind the HALT.
  assign w_load_instr = w_running ? imem_data : NOP_INSTR;

  if_id_reg #(
    .PC_W(PC_W)
  ) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .i_flush (branch_taken),
    .i_hold  (stall),
    .i_instr (w_load_instr),
    .i_pc    (r_pc),
    .i_valid (w_running),
    .o_instr (id_instr),
    .o_pc    (id_pc),
    .o_valid (id_valid)
  );

  assign imem_addr    = r_pc;
  assign id_opcode    = id_instr[OPC_LSB +: OPC_W];
  assign id_w         = id_instr[W_LSB +: REG_W];
  assign id_r1        = id_instr[R1_LSB +: REG_W];
  assign id_r2        = id_instr[R2_LSB +: REG_W];
  assign halted       = (r_state == FETCH_HALTED);
  assign stall_cycles = r_stall_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: two instances (RESET_PC 0 / 16-bit counter, RESET_PC FE / 3-bit counter) against a behavioural model.
module tb_fetch_stage;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       stall = 1'b0;
  logic       branch_taken = 1'b0;
  logic [7:0] branch_target = 8'h00;

  logic [15:0] imem [256];

  logic [7:0]  a_addr, a_pc;
  logic [15:0] a_data, a_instr, a_cnt;
  logic [3:0]  a_opc;
  logic [2:0]  a_w, a_r1, a_r2;
  logic        a_valid, a_halted;

  logic [7:0]  b_addr, b_pc;
  logic [15:0] b_data, b_instr;
  logic [2:0]  b_cnt;
  logic [3:0]  b_opc;
  logic [2:0]  b_w, b_r1, b_r2;
  logic        b_valid, b_halted;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign a_data = imem[a_addr];
  assign b_data = imem[b_addr];

  fetch_stage #(.PC_W(8), .RESET_PC(8'h00), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_addr(a_addr), .imem_data(a_data),
    .id_instr(a_instr), .id_opcode(a_opc), .id_w(a_w), .id_r1(a_r1), .id_r2(a_r2),
    .id_pc(a_pc), .id_valid(a_valid), .halted(a_halted), .stall_cycles(a_cnt)
  );

  fetch_stage #(.PC_W(8), .RESET_PC(8'hFE), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_addr(b_addr), .imem_data(b_data),
    .id_instr(b_instr), .id_opcode(b_opc), .id_w(b_w), .id_r1(b_r1), .id_r2(b_r2),
    .id_pc(b_pc), .id_valid(b_valid), .halted(b_halted), .stall_cycles(b_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: architectural state of one fetch stage.
  typedef struct {
    logic [7:0]  pc;
    logic [15:0] instr;
    logic [7:0]  ipc;
    logic        valid;
    logic        halted;
    int unsigned cnt;
  } mstate_t;

  mstate_t ma, mb;
  logic    model_on = 1'b0;

  function automatic mstate_t model_step(input mstate_t s, input logic [7:0] rpc,
                                         input int unsigned cmax);
    mstate_t     n;
    logic [15:0] word;
    n    = s;
    word = imem[s.pc];
    if (rst) begin
      n.pc = rpc; n.instr = 16'h0000; n.ipc = 8'h00; n.valid = 1'b0;
      n.halted = 1'b0; n.cnt = 0;
    end else if (branch_taken) begin
      n.pc = branch_target; n.instr = 16'h0000; n.valid = 1'b0; n.halted = 1'b0;
    end else if (stall) begin
      n.cnt = (s.cnt >= cmax) ? cmax : s.cnt + 1;
    end else if (s.halted) begin
      n.instr = 16'h0000; n.valid = 1'b0;
    end else begin
      n.instr = word; n.ipc = s.pc; n.valid = 1'b1;
      if (word[15:12] == 4'hF) n.halted = 1'b1;
      else n.pc = s.pc + 8'd1;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    ma = model_step(ma, 8'h00, 65535);
    mb = model_step(mb, 8'hFE, 7);
    if (rst) model_on = 1'b1;
  end

  always @(negedge clk) begin
    if (model_on) begin
      check("a.addr",   {24'b0, a_addr},  {24'b0, ma.pc});
      check("a.instr",  {16'b0, a_instr}, {16'b0, ma.instr});
      check("a.fields", {16'b0, a_opc, a_w, a_r1, a_r2, 3'b0},
                        {16'b0, ma.instr[15:3], 3'b0});
      check("a.valid",  {31'b0, a_valid},  {31'b0, ma.valid});
      check("a.halted", {31'b0, a_halted}, {31'b0, ma.halted});
      check("a.cnt",    {16'b0, a_cnt},    ma.cnt);
      if (ma.valid) check("a.id_pc", {24'b0, a_pc}, {24'b0, ma.ipc});
      check("b.addr",   {24'b0, b_addr},  {24'b0, mb.pc});
      check("b.instr",  {16'b0, b_instr}, {16'b0, mb.instr});
      check("b.fields", {16'b0, b_opc, b_w, b_r1, b_r2, 3'b0},
                        {16'b0, mb.instr[15:3], 3'b0});
      check("b.valid",  {31'b0, b_valid},  {31'b0, mb.valid});
      check("b.halted", {31'b0, b_halted}, {31'b0, mb.halted});
      check("b.cnt",    {29'b0, b_cnt},    mb.cnt);
      if (mb.valid) check("b.id_pc", {24'b0, b_pc}, {24'b0, mb.ipc});
    end
  end

  task automatic step(input logic st, input logic bt, input logic [7:0] tgt);
    stall = st;
    branch_taken = bt;
    branch_target = tgt;
    @(negedge clk);
  endtask

  task automatic check_reset_values();
    check("rst a.addr",   {24'b0, a_addr}, 32'h00);
    check("rst b.addr",   {24'b0, b_addr}, 32'hFE);
    check("rst a.instr",  {16'b0, a_instr}, 32'h0);
    check("rst a.valid",  {31'b0, a_valid}, 32'h0);
    check("rst a.halted", {31'b0, a_halted}, 32'h0);
    check("rst a.cnt",    {16'b0, a_cnt}, 32'h0);
    check("rst b.cnt",    {29'b0, b_cnt}, 32'h0);
    check("rst a.id_pc",  {24'b0, a_pc}, 32'h0);
  endtask

  logic [7:0] wrap_exp [4];

  initial begin
    for (int a = 0; a < 256; a++) imem[a] = 16'h1000 + 16'(a);
    imem[6] = 16'hF000;
    wrap_exp = '{8'hFE, 8'hFF, 8'h00, 8'h01};

    rst = 1'b1;
    step(0, 0, 8'h00);
    step(0, 0, 8'h00);
    check_reset_values();
    rst = 1'b0;

    // Free run: one-edge latency, wrap on the FE instance.
    for (int i = 0; i < 4; i++) begin
      check("run a.addr", {24'b0, a_addr}, i);
      check("wrap b.addr", {24'b0, b_addr}, {24'b0, wrap_exp[i]});
      step(0, 0, 8'h00);
      check("run a.instr", {16'b0, a_instr}, 32'h1000 + i);
      check("run a.id_pc", {24'b0, a_pc}, i);
      check("run a.valid", {31'b0, a_valid}, 32'h1);
    end
    step(0, 0, 8'h00);
    check("pre-stall a.addr", {24'b0, a_addr}, 32'h05);

    for (int k = 0; k < 3; k++) begin
      step(1, 0, 8'h00);
      check("stall a.cnt",   {16'b0, a_cnt}, k + 1);
      check("stall a.addr",  {24'b0, a_addr}, 32'h05);
      check("stall a.instr", {16'b0, a_instr}, 32'h1004);
    end
    step(0, 0, 8'h00);
    check("resume a.instr", {16'b0, a_instr}, 32'h1005);

    // HALT at address 6.
    step(0, 0, 8'h00);
    check("halt a.instr",  {16'b0, a_instr}, 32'hF000);
    check("halt a.valid",  {31'b0, a_valid}, 32'h1);
    check("halt a.halted", {31'b0, a_halted}, 32'h1);
    check("halt a.addr",   {24'b0, a_addr}, 32'h06);
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 8'h00);
      check("drain a.valid", {31'b0, a_valid}, 32'h0);
      check("drain a.addr",  {24'b0, a_addr}, 32'h06);
    end
    step(1, 0, 8'h00);
    check("halted stall a.halted", {31'b0, a_halted}, 32'h1);

    step(0, 1, 8'h10);
    check("unhalt a.halted", {31'b0, a_halted}, 32'h0);
    check("unhalt a.addr",   {24'b0, a_addr}, 32'h10);
    step(0, 0, 8'h00);
    step(0, 0, 8'h00);
    check("post-branch a.instr", {16'b0, a_instr}, 32'h1011);

    // Redirect beats stall and does not count.
    step(1, 1, 8'h40);
    check("redir a.addr",  {24'b0, a_addr}, 32'h40);
    check("redir a.valid", {31'b0, a_valid}, 32'h0);
    check("redir a.instr", {16'b0, a_instr}, 32'h0);
    check("redir a.cnt",   {16'b0, a_cnt}, 32'h4);
    step(0, 0, 8'h00);
    check("post-redir a.instr", {16'b0, a_instr}, 32'h1040);

    for (int k = 0; k < 5; k++) step(1, 0, 8'h00);
    check("sat a.cnt", {16'b0, a_cnt}, 32'h9);
    check("sat b.cnt", {29'b0, b_cnt}, 32'h7);

    // Reset while stalled.
    rst = 1'b1;
    step(1, 0, 8'h00);
    check_reset_values();
    rst = 1'b0;
    step(0, 0, 8'h00);
    check("after rst a.instr", {16'b0, a_instr}, 32'h1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
